// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the UART: serial line and baud tick in, recovered word and frame status out.
// The master drives the line side; the receiver attaches through the slave modport.
interface uart_receiver_if #(
   parameter int DBIT = 8
);
   logic            rx;
   logic            s_tick;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;
   logic            parity_err;
   logic            busy;

   modport master (
      output rx, s_tick,
      input  dout, rx_done_tick, frame_err, parity_err, busy
   );

   modport slave (
      input  rx, s_tick,
      output dout, rx_done_tick, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop recovery with a one-clock done strobe.
// dout and the error flags are held until the next completed frame overwrites them.
module uart_receiver #(
   parameter int DBIT      = 8,
   parameter int SB_TICK   = 16,
   parameter int PARITY_EN = 0,
   parameter int PARITY_OD = 0
) (
   input  logic           clk,
   input  logic           reset,
   uart_receiver_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t          state;
   logic            rx_meta;
   logic            rx_s;
   logic [4:0]      s;
   logic [2:0]      n;
   logic [DBIT-1:0] shift_reg;
   logic            p;
   logic [DBIT-1:0] dout_reg;
   logic            done_reg;
   logic            frame_err_reg;
   logic            parity_err_reg;
   logic            busy_reg;

   // rx is asynchronous to clk; both stages reset to the idle-high line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         s              <= 5'd0;
         n              <= 3'd0;
         shift_reg      <= '0;
         p              <= 1'b0;
         dout_reg       <= '0;
         done_reg       <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  s        <= 5'd0;
                  busy_reg <= 1'b1;
               end
            end
            // A start bit that is high again at its midpoint is treated as line noise.
            START: begin
               if (s_tick_q()) begin
                  if (s == 5'd7) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= 5'd0;
                        n     <= 3'd0;
                     end else begin
                        state    <= IDLE;
                        busy_reg <= 1'b0;
                     end
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick_q()) begin
                  if (s == 5'd15) begin
                     shift_reg <= {rx_s, shift_reg[DBIT-1:1]};
                     s         <= 5'd0;
                     if (n == 3'(DBIT - 1)) begin
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                     end else begin
                        n <= n + 3'd1;
                     end
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end
            PARITY: begin
               if (s_tick_q()) begin
                  if (s == 5'd15) begin
                     p     <= rx_s;
                     s     <= 5'd0;
                     state <= STOP;
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end
            // Results are published together with the return to IDLE so the strobe lands one clk after the stop sample.
            STOP: begin
               if (s_tick_q()) begin
                  if (s == 5'(SB_TICK - 1)) begin
                     state          <= IDLE;
                     busy_reg       <= 1'b0;
                     done_reg       <= 1'b1;
                     dout_reg       <= shift_reg;
                     frame_err_reg  <= ~rx_s;
                     parity_err_reg <= (PARITY_EN != 0) & (^shift_reg ^ p ^ (PARITY_OD != 0));
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   function automatic logic s_tick_q();
      return bus.s_tick;
   endfunction

   assign bus.dout         = dout_reg;
   assign bus.rx_done_tick = done_reg;
   assign bus.frame_err    = frame_err_reg;
   assign bus.parity_err   = parity_err_reg;
   assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver: one default instance and one even-parity instance share clk and baud tick.
module tb_uart_receiver;

   localparam int BIT_CLKS = 64;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   strobes_a = 0;
   int   strobes_p = 0;
   exp_t sb_q[$];

   uart_receiver_if #(.DBIT(8)) bus_a ();
   uart_receiver_if #(.DBIT(8)) bus_p ();

   uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_OD(0)) dut_a (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_a)
   );

   uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_OD(0)) dut_p (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_p)
   );

   always #5 clk = ~clk;

   initial begin
      bus_a.s_tick = 1'b0;
      bus_p.s_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus_a.s_tick = 1'b1;
         bus_p.s_tick = 1'b1;
         @(negedge clk);
         bus_a.s_tick = 1'b0;
         bus_p.s_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus_a.rx_done_tick === 1'b1) strobes_a++;
      if (bus_p.rx_done_tick === 1'b1) strobes_p++;
   end

   task automatic drive_rx(input bit which, input logic v);
      if (which) bus_p.rx = v;
      else       bus_a.rx = v;
   endtask

   task automatic send_frame(input bit which, input logic [7:0] data, input bit use_par,
                             input logic par_bit, input logic stop_bit, input int stop_clks);
      drive_rx(which, 1'b0);
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive_rx(which, data[i]);
         repeat (BIT_CLKS) @(negedge clk);
      end
      if (use_par) begin
         drive_rx(which, par_bit);
         repeat (BIT_CLKS) @(negedge clk);
      end
      drive_rx(which, stop_bit);
      repeat (stop_clks) @(negedge clk);
      drive_rx(which, 1'b1);
   endtask

   task automatic wait_strobe(input bit which, output bit got, output logic [7:0] d,
                              output logic fe, output logic pe);
      got = 1'b0;
      d   = 8'h00;
      fe  = 1'b0;
      pe  = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (which ? bus_p.rx_done_tick : bus_a.rx_done_tick) begin
            got = 1'b1;
            d   = which ? bus_p.dout       : bus_a.dout;
            fe  = which ? bus_p.frame_err  : bus_a.frame_err;
            pe  = which ? bus_p.parity_err : bus_a.parity_err;
         end
      end
   endtask

   task automatic test_reset();
      bus_a.rx = 1'b1;
      bus_p.rx = 1'b1;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.dout, bus_a.rx_done_tick, bus_a.frame_err, bus_a.parity_err, bus_a.busy} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_a: outputs=%h expected 000", {bus_a.dout, bus_a.rx_done_tick, bus_a.frame_err, bus_a.parity_err, bus_a.busy});
      end
      checks++;
      if ({bus_p.dout, bus_p.rx_done_tick, bus_p.frame_err, bus_p.parity_err, bus_p.busy} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_p: outputs=%h expected 000", {bus_p.dout, bus_p.rx_done_tick, bus_p.frame_err, bus_p.parity_err, bus_p.busy});
      end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || strobes_a != 0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: busy=%b strobes=%0d expected busy=0 strobes=0", bus_a.busy, strobes_a);
      end
   endtask

   task automatic test_single_frame();
      bit got; logic [7:0] d; logic fe, pe; exp_t e; int base;
      base = strobes_a;
      sb_q.push_back('{data: 8'h55, fe: 1'b0, pe: 1'b0});
      fork
         send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, BIT_CLKS);
         wait_strobe(1'b0, got, d, fe, pe);
      join
      e = sb_q.pop_front();
      checks++;
      if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
         errors++;
         $display("[TB] FAIL frame_55: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", got, d, fe, pe, e.data, e.fe, e.pe);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || strobes_a - base != 1) begin
         errors++;
         $display("[TB] FAIL frame_55_after: busy=%b strobes=%0d expected busy=0 strobes=1", bus_a.busy, strobes_a - base);
      end
   endtask

   task automatic test_glitch();
      int base; logic [7:0] old_dout;
      base     = strobes_a;
      old_dout = bus_a.dout;
      bus_a.rx = 1'b0;
      repeat (16) @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL glitch_busy: busy=%b expected 1", bus_a.busy);
      end
      bus_a.rx = 1'b1;
      repeat (120) @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || strobes_a != base || bus_a.dout !== old_dout) begin
         errors++;
         $display("[TB] FAIL glitch_reject: busy=%b strobes=%0d dout=%h expected busy=0 strobes=0 dout=%h",
                  bus_a.busy, strobes_a - base, bus_a.dout, old_dout);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      for (int i = 0; i < 3; i++) begin
         bytes[i] = 8'($urandom_range(0, 255));
         sb_q.push_back('{data: bytes[i], fe: 1'b0, pe: 1'b0});
      end
      fork
         begin
            for (int i = 0; i < 3; i++) send_frame(1'b0, bytes[i], 1'b0, 1'b0, 1'b1, BIT_CLKS);
         end
         begin
            bit got; logic [7:0] d; logic fe, pe; exp_t e;
            for (int k = 0; k < 3; k++) begin
               wait_strobe(1'b0, got, d, fe, pe);
               e = sb_q.pop_front();
               checks++;
               if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
                  errors++;
                  $display("[TB] FAIL b2b_%0d: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", k, got, d, fe, pe, e.data, e.fe, e.pe);
               end
            end
         end
      join
      repeat (40) @(negedge clk);
   endtask

   task automatic test_frame_error();
      bit got; logic [7:0] d; logic fe, pe; exp_t e; int base;
      base = strobes_a;
      // Bad stop bit is shortened so the line is high again before a restarted START samples it.
      sb_q.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0});
      fork
         send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48);
         wait_strobe(1'b0, got, d, fe, pe);
      join
      e = sb_q.pop_front();
      checks++;
      if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
         errors++;
         $display("[TB] FAIL frame_err: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", got, d, fe, pe, e.data, e.fe, e.pe);
      end
      repeat (150) @(negedge clk);
      checks++;
      if (strobes_a - base != 1 || bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL frame_err_strobes: strobes=%0d busy=%b expected strobes=1 busy=0", strobes_a - base, bus_a.busy);
      end
      sb_q.push_back('{data: 8'h81, fe: 1'b0, pe: 1'b0});
      fork
         send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_CLKS);
         wait_strobe(1'b0, got, d, fe, pe);
      join
      e = sb_q.pop_front();
      checks++;
      if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
         errors++;
         $display("[TB] FAIL frame_err_clear: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", got, d, fe, pe, e.data, e.fe, e.pe);
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_parity();
      logic pbits [2];
      pbits[0] = 1'b1;
      pbits[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bit got; logic [7:0] d; logic fe, pe; exp_t e;
         sb_q.push_back('{data: 8'h07, fe: 1'b0, pe: (^8'h07) ^ pbits[i]});
         fork
            send_frame(1'b1, 8'h07, 1'b1, pbits[i], 1'b1, BIT_CLKS);
            wait_strobe(1'b1, got, d, fe, pe);
         join
         e = sb_q.pop_front();
         checks++;
         if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
            errors++;
            $display("[TB] FAIL parity_p%0b: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", pbits[i], got, d, fe, pe, e.data, e.fe, e.pe);
         end
         repeat (40) @(negedge clk);
      end
      checks++;
      if (strobes_p != 2) begin
         errors++;
         $display("[TB] FAIL parity_strobes: strobes=%0d expected 2", strobes_p);
      end
   endtask

   task automatic test_reset_midframe();
      bit got; logic [7:0] d; logic fe, pe; exp_t e; int base;
      fork
         send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, BIT_CLKS);
         begin
            repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
            checks++;
            if (bus_a.busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL midframe_busy: busy=%b expected 1", bus_a.busy);
            end
            reset = 1'b1;
            #1;
            checks++;
            if ({bus_a.dout, bus_a.rx_done_tick, bus_a.frame_err, bus_a.parity_err, bus_a.busy} !== 12'h000) begin
               errors++;
               $display("[TB] FAIL midframe_reset: outputs=%h expected 000", {bus_a.dout, bus_a.rx_done_tick, bus_a.frame_err, bus_a.parity_err, bus_a.busy});
            end
         end
      join
      base = strobes_a;
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      if (strobes_a != base || bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midframe_stray: strobes=%0d busy=%b expected strobes=0 busy=0", strobes_a - base, bus_a.busy);
      end
      sb_q.push_back('{data: 8'h3C, fe: 1'b0, pe: 1'b0});
      fork
         send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, BIT_CLKS);
         wait_strobe(1'b0, got, d, fe, pe);
      join
      e = sb_q.pop_front();
      checks++;
      if (!got || {d, fe, pe} !== {e.data, e.fe, e.pe}) begin
         errors++;
         $display("[TB] FAIL after_reset_frame: got=%0b dout=%h fe=%b pe=%b expected dout=%h fe=%b pe=%b", got, d, fe, pe, e.data, e.fe, e.pe);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (strobes_a - base != 1) begin
         errors++;
         $display("[TB] FAIL after_reset_strobes: strobes=%0d expected 1", strobes_a - base);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_glitch();
      test_back_to_back();
      test_frame_error();
      test_parity();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
